// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad column scanner.
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} kp_state_t;

    localparam logic [3:0] COL_FIRST = 4'b0001;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Next column in the 0001 -> 0010 -> 0100 -> 1000 -> 0001 rotation.
    function automatic logic [3:0] rotate_col(input logic [3:0] c);
        return {c[2:0], c[3]};
    endfunction

endpackage

// File: rtl/keypad_col_scanner_sync_2ff.sv
// Reset-clearable two-flop synchroniser for asynchronous keypad inputs.
module sync_2ff #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_col_scanner.sv
// Column strobe driver, row debouncer and press detector for a 4x4 keypad.
module keypad_col_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 8
) (
    input  logic       slow_clk,
    input  logic       rst,
    input  logic [3:0] row_raw,
    output logic [3:0] col_shift_reg,
    output logic [3:0] row_out,
    output logic       key_strobe,
    output logic       busy
);

    localparam int unsigned CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DB_DONE  = CNT_W'(DEBOUNCE_CYCLES);

    logic [3:0]       row_s;
    kp_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic [3:0]       cand, cand_nxt;
    logic [3:0]       col_nxt;
    logic [3:0]       row_out_nxt;
    logic             strobe_nxt;
    logic             busy_nxt;

    sync_2ff #(.W(4)) u_row_sync (
        .clk (slow_clk),
        .rst (rst),
        .d   (row_raw),
        .q   (row_s)
    );

    // Shared divider/debounce counter saturates instead of wrapping.
    assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

    always_ff @(posedge slow_clk) begin
        if (!rst) begin
            state         <= SCAN;
            cnt           <= '0;
            cand          <= '0;
            col_shift_reg <= COL_FIRST;
            row_out       <= '0;
            key_strobe    <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            cand          <= cand_nxt;
            col_shift_reg <= col_nxt;
            row_out       <= row_out_nxt;
            key_strobe    <= strobe_nxt;
            busy          <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        cand_nxt    = cand;
        col_nxt     = col_shift_reg;
        row_out_nxt = row_out;
        strobe_nxt  = 1'b0;

        case (state)
            // A one-hot row beats a divider wrap, so the pressed column stays put.
            SCAN: begin
                if (is_onehot4(row_s)) begin
                    state_nxt = DEBOUNCE;
                    cand_nxt  = row_s;
                    cnt_nxt   = '0;
                end else if (cnt >= DIV_LAST) begin
                    cnt_nxt = '0;
                    col_nxt = rotate_col(col_shift_reg);
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            DEBOUNCE: begin
                if (row_s == cand) begin
                    if (cnt_inc >= DB_DONE) begin
                        state_nxt   = HOLD;
                        row_out_nxt = cand;
                        strobe_nxt  = 1'b1;
                        cnt_nxt     = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end else begin
                    state_nxt = SCAN;
                    cnt_nxt   = '0;
                    col_nxt   = rotate_col(col_shift_reg);
                end
            end
            HOLD: begin
                if (row_s == 4'd0) begin
                    state_nxt = RELEASE;
                    cnt_nxt   = '0;
                end
            end
            RELEASE: begin
                if (row_s != 4'd0) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                end else if (cnt_inc >= DB_DONE) begin
                    state_nxt   = SCAN;
                    row_out_nxt = '0;
                    cnt_nxt     = '0;
                    col_nxt     = rotate_col(col_shift_reg);
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = SCAN;
                cnt_nxt   = '0;
            end
        endcase

        // Guard the one-hot column drive against any corrupted register value.
        if (!is_onehot4(col_nxt)) begin
            col_nxt = COL_FIRST;
        end

        busy_nxt = (state_nxt != SCAN);
    end

endmodule

// File: tb/tb_keypad_col_scanner.sv
// Randomised and directed bench for keypad_col_scanner against a run-length reference model.
module tb_keypad_col_scanner;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DB       = 8;

    logic       slow_clk = 1'b0;
    logic       rst      = 1'b0;
    logic [3:0] row_raw  = 4'd0;
    logic [3:0] col_shift_reg;
    logic [3:0] row_out;
    logic       key_strobe;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Reference model: sync pipe plus run-length bookkeeping.
    logic [3:0] m_s1, m_s2;
    int         m_col_idx, m_tick, m_run, m_zeros;
    bit         m_busy, m_held, m_strobe;
    logic [3:0] m_cand, m_row_out;

    keypad_col_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DB)) dut (
        .slow_clk      (slow_clk),
        .rst           (rst),
        .row_raw       (row_raw),
        .col_shift_reg (col_shift_reg),
        .row_out       (row_out),
        .key_strobe    (key_strobe),
        .busy          (busy)
    );

    always #5 slow_clk = ~slow_clk;

    function automatic void model_reset();
        m_s1 = 4'd0; m_s2 = 4'd0;
        m_col_idx = 0; m_tick = 0; m_run = 0; m_zeros = 0;
        m_busy = 0; m_held = 0; m_strobe = 0;
        m_cand = 4'd0; m_row_out = 4'd0;
    endfunction

    function automatic void model_step();
        logic [3:0] s;
        if (!rst) begin
            model_reset();
            return;
        end
        s = m_s2;
        m_s2 = m_s1;
        m_s1 = row_raw;
        m_strobe = 0;
        if (!m_busy) begin
            if ($countones(s) == 1) begin
                m_busy = 1; m_cand = s; m_run = 0;
            end else begin
                m_tick++;
                if (m_tick == SCAN_DIV) begin
                    m_tick = 0; m_col_idx = (m_col_idx + 1) % 4;
                end
            end
        end else if (!m_held) begin
            // Press accepted after capture sample plus DB further matching samples.
            if (s == m_cand) begin
                m_run++;
                if (m_run == DB) begin
                    m_held = 1; m_row_out = m_cand; m_strobe = 1; m_zeros = 0;
                end
            end else begin
                m_busy = 0; m_tick = 0; m_col_idx = (m_col_idx + 1) % 4;
            end
        end else begin
            // Release needs DB+1 consecutive zero samples.
            if (s == 4'd0) begin
                m_zeros++;
                if (m_zeros == DB + 1) begin
                    m_held = 0; m_busy = 0; m_row_out = 4'd0; m_tick = 0;
                    m_col_idx = (m_col_idx + 1) % 4;
                end
            end else begin
                m_zeros = 0;
            end
        end
    endfunction

    function automatic logic [9:0] exp_vec();
        return {4'(32'd1 << m_col_idx), m_row_out, m_strobe, m_busy};
    endfunction

    task automatic step();
        @(posedge slow_clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] rot [4];
        rot = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst = 1'b0; row_raw = 4'hF;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({col_shift_reg, row_out, key_strobe, busy} !== {4'b0001, 4'b0000, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset cyc %0d: got %b want %b", i, {col_shift_reg, row_out, key_strobe, busy}, {4'b0001, 4'b0000, 2'b00});
            end
        end
        rst = 1'b1; row_raw = 4'd0;
        for (int k = 0; k < 4; k++) begin
            repeat (SCAN_DIV) step();
            checks++;
            if (col_shift_reg !== rot[k]) begin
                errors++;
                $display("FAIL reset_rotate step %0d: got %b want %b", k, col_shift_reg, rot[k]);
            end
        end
    endtask

    task automatic test_clean_press();
        int n_strobe = 0;
        int waited = 0;
        while (m_col_idx != 2 && waited < 40) begin
            step(); waited++;
        end
        checks++;
        if (col_shift_reg !== 4'b0100) begin
            errors++;
            $display("FAIL clean_wait_col: got %b want %b", col_shift_reg, 4'b0100);
        end
        row_raw = 4'b0010;
        for (int i = 1; i <= 30; i++) begin
            step();
            n_strobe += int'(key_strobe);
            checks++;
            if ({col_shift_reg, row_out, key_strobe, busy} !== exp_vec()) begin
                errors++;
                $display("FAIL clean_press cyc %0d: got %b want %b", i, {col_shift_reg, row_out, key_strobe, busy}, exp_vec());
            end
            if (i == 11) begin
                checks++;
                if ({col_shift_reg, row_out, key_strobe} !== {4'b0100, 4'b0010, 1'b1}) begin
                    errors++;
                    $display("FAIL clean_strobe_time: got %b want %b", {col_shift_reg, row_out, key_strobe}, {4'b0100, 4'b0010, 1'b1});
                end
            end
        end
        row_raw = 4'd0;
        for (int i = 1; i <= 20; i++) begin
            step();
            checks++;
            if ({col_shift_reg, row_out, key_strobe, busy} !== exp_vec()) begin
                errors++;
                $display("FAIL clean_release cyc %0d: got %b want %b", i, {col_shift_reg, row_out, key_strobe, busy}, exp_vec());
            end
            if (i == 10 || i == 11) begin
                checks++;
                if (row_out !== ((i == 10) ? 4'b0010 : 4'b0000)) begin
                    errors++;
                    $display("FAIL clean_release_time cyc %0d: got %b", i, row_out);
                end
            end
        end
        checks++;
        if (n_strobe != 1) begin
            errors++;
            $display("FAIL clean_strobe_count: got %0d want 1", n_strobe);
        end
    endtask

    task automatic test_bouncy_press();
        int n_bounce = 0;
        int n_total = 0;
        for (int i = 0; i < 50; i++) begin
            if (i < 18)      row_raw = ((i / 3) % 2 == 0) ? 4'b1000 : 4'b0000;
            else if (i < 30) row_raw = 4'b1000;
            else             row_raw = 4'b0000;
            step();
            if (i < 18) n_bounce += int'(key_strobe);
            n_total += int'(key_strobe);
            checks++;
            if ({col_shift_reg, row_out, key_strobe, busy} !== exp_vec()) begin
                errors++;
                $display("FAIL bouncy cyc %0d: got %b want %b", i, {col_shift_reg, row_out, key_strobe, busy}, exp_vec());
            end
        end
        checks++;
        if (n_bounce != 0 || n_total != 1) begin
            errors++;
            $display("FAIL bouncy_strobes: got bounce=%0d total=%0d want 0 and 1", n_bounce, n_total);
        end
    endtask

    task automatic test_release_bounce();
        int n_strobe = 0;
        for (int i = 0; i < 34; i++) begin
            if (i < 12)      row_raw = 4'b1000;
            else if (i < 16) row_raw = 4'b0000;
            else if (i < 18) row_raw = 4'b1000;
            else             row_raw = 4'b0000;
            step();
            n_strobe += int'(key_strobe);
            checks++;
            if ({col_shift_reg, row_out, key_strobe, busy} !== exp_vec()) begin
                errors++;
                $display("FAIL rel_bounce cyc %0d: got %b want %b", i, {col_shift_reg, row_out, key_strobe, busy}, exp_vec());
            end
            if (i == 27 || i == 28) begin
                checks++;
                if (row_out !== ((i == 27) ? 4'b1000 : 4'b0000)) begin
                    errors++;
                    $display("FAIL rel_bounce_time cyc %0d: got %b", i, row_out);
                end
            end
        end
        checks++;
        if (n_strobe != 1) begin
            errors++;
            $display("FAIL rel_bounce_strobes: got %0d want 1", n_strobe);
        end
    endtask

    task automatic test_multi_hot();
        int n_busy = 0;
        int n_rot = 0;
        logic [3:0] prev_col;
        row_raw = 4'b1100;
        prev_col = col_shift_reg;
        for (int i = 0; i < 20; i++) begin
            step();
            n_busy += int'(busy) + int'(key_strobe);
            if (col_shift_reg != prev_col) n_rot++;
            prev_col = col_shift_reg;
            checks++;
            if ({col_shift_reg, row_out, key_strobe, busy} !== exp_vec()) begin
                errors++;
                $display("FAIL multi_hot cyc %0d: got %b want %b", i, {col_shift_reg, row_out, key_strobe, busy}, exp_vec());
            end
        end
        checks++;
        if (n_busy != 0 || n_rot < 4) begin
            errors++;
            $display("FAIL multi_hot_scan: got busy+strobe=%0d rotations=%0d want 0 and >=4", n_busy, n_rot);
        end
        row_raw = 4'd0;
        repeat (4) step();
    endtask

    task automatic test_reset_mid();
        int waited;
        for (int phase = 0; phase < 2; phase++) begin
            row_raw = 4'b0100;
            waited = 0;
            while (!(phase == 0 ? (m_busy && !m_held && m_run == 5) : m_held) && waited < 40) begin
                step(); waited++;
            end
            checks++;
            if (waited >= 40) begin
                errors++;
                $display("FAIL reset_mid_wait phase %0d: timeout", phase);
            end
            rst = 1'b0;
            step();
            checks++;
            if ({col_shift_reg, row_out, key_strobe, busy} !== {4'b0001, 4'b0000, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset_mid phase %0d: got %b want %b", phase, {col_shift_reg, row_out, key_strobe, busy}, {4'b0001, 6'd0});
            end
            rst = 1'b1;
        end
        row_raw = 4'd0;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if ({col_shift_reg, row_out, key_strobe, busy} !== exp_vec()) begin
                errors++;
                $display("FAIL reset_mid_after cyc %0d: got %b want %b", i, {col_shift_reg, row_out, key_strobe, busy}, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        int hold;
        int r;
        logic prev_strobe = 1'b0;
        for (int seg = 0; seg < 180; seg++) begin
            r = $urandom_range(0, 19);
            rst = 1'b1;
            if (r < 8)       row_raw = 4'd0;
            else if (r < 16) row_raw = 4'(32'd1 << $urandom_range(0, 3));
            else if (r < 19) row_raw = 4'($urandom_range(1, 15));
            else             rst = 1'b0;
            hold = (rst == 1'b0) ? 1 : $urandom_range(1, 14);
            for (int i = 0; i < hold; i++) begin
                step();
                checks++;
                if ({col_shift_reg, row_out, key_strobe, busy} !== exp_vec()) begin
                    errors++;
                    $display("FAIL random seg %0d cyc %0d: got %b want %b", seg, i, {col_shift_reg, row_out, key_strobe, busy}, exp_vec());
                end
                checks++;
                if ((key_strobe && prev_strobe) || $countones(col_shift_reg) != 1) begin
                    errors++;
                    $display("FAIL random_invariant seg %0d: col %b strobe %b prev %b", seg, col_shift_reg, key_strobe, prev_strobe);
                end
                prev_strobe = key_strobe;
            end
        end
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_clean_press();
        test_bouncy_press();
        test_release_bounce();
        test_multi_hot();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
